udp_pixel_decoder: RTL and testbench
====================================

UDP_PIXEL_DECODER -- requirements
Module: udp_pixel_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, pixel address width per channel (1..24).
REQ-002 SHALL have parameter CH_NUM, default 1, number of panel channels (1..64).
REQ-003 SHALL have port clk_125  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid  in  1  UDP payload byte valid.
REQ-006 SHALL have port s_last  in  1  last byte of datagram.
REQ-007 SHALL have port s_data  in  8  payload byte, big-endian word order.
REQ-008 SHALL have port s_length  in  16  payload byte count of current datagram.
REQ-009 SHALL have port s_ready  out  1  constant 1; no backpressure.
REQ-010 SHALL have port wr_en  out  CH_NUM  one-hot pixel write strobe.
REQ-011 SHALL have port wr_addr  out  ADDR_W  pixel write address.
REQ-012 SHALL have port wr_data  out  30  pixel payload.
REQ-013 SHALL have port commit  out  CH_NUM  one-cycle frame-commit pulse per channel.
REQ-014 SHALL have port err  out  1  one-cycle pulse on protocol error.

Function
REQ-015 SHALL pack bytes into 32-bit words MSB-first; word complete on every 4th accepted byte of a datagram.
REQ-016 SHALL ignore bytes whose in-datagram index >= s_length (padding); byte index resets after s_last.
REQ-017 SHALL discard a partial word (1-3 bytes) left at s_last, with no strobe and no err.
REQ-018 SHALL decode word[31:30]: 00 SET_ADDR, 01 COMMIT, 10 illegal, 11 PIXEL.
REQ-019 SET_ADDR SHALL load channel = word[29:24], address = word[23:0].
REQ-020 SET_ADDR SHALL set a "target valid" flag only if channel < CH_NUM and word[23:ADDR_W] == 0; otherwise SHALL clear it and pulse err.
REQ-021 PIXEL SHALL, when target valid, assert wr_en[channel] for one cycle with current address and wr_data = word[29:0], then increment the address.
REQ-022 PIXEL SHALL suppress the write when target invalid, without err.
REQ-023 Address increment from 2^ADDR_W-1 SHALL clear target valid (no wrap); subsequent PIXEL words are dropped until the next SET_ADDR.
REQ-024 COMMIT SHALL pulse commit[word[29:24]] for one cycle if channel < CH_NUM; otherwise SHALL pulse err.
REQ-025 Illegal opcode SHALL pulse err and enter DROP.
REQ-026 Decoded outputs SHALL register exactly 1 cycle after the completing byte is accepted.
REQ-027 States SHALL be IDLE -> RECV on the first valid byte; RECV -> IDLE on s_last; RECV -> DROP on illegal opcode; DROP -> IDLE on s_last.
REQ-028 In DROP, all bytes SHALL be ignored.
REQ-029 Address and target state SHALL persist across datagrams.
REQ-030 s_last together with a completing 4th byte SHALL still decode that word.

Reset
REQ-031 Reset SHALL clear wr_en, commit, err, byte index, word shift register, target valid and address, and enter IDLE; s_ready remains 1.
REQ-032 Reset mid-datagram SHALL abandon the datagram; the following bytes, up to s_last, SHALL be treated as a new datagram.

Configuration
REQ-033 With UDP_PIXEL_DECODER_STATS_EN defined, the block SHALL add outputs stat_pkts[31:0] (datagrams seen), stat_pix[31:0] (pixels written) and stat_err[15:0] (err pulses); all saturating, cleared by reset.
REQ-034 Without UDP_PIXEL_DECODER_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-035 The shared package pixel_proto_pkg SHALL hold the opcode constants, the state enum, the field bit positions (channel [29:24], address [23:0]) and the payload width 30.
REQ-036 One sub-module, byte_word_packer (byte index, length gating, 32-bit assembly, word-valid strobe), SHALL be instantiated.

Verification
REQ-037 Bytes 00 00 00 10, C0 00 00 01, C0 00 00 02 -> wr_en[0] at addr 0x10 with data 0x1, then at 0x11 with data 0x2.
REQ-038 SET_ADDR 0x00002000 (ADDR_W=13) -> err pulse; following PIXEL words produce no wr_en.
REQ-039 CH_NUM=4; COMMIT word 0x43000000 -> commit=4'b1000 for 1 cycle; COMMIT 0x44000000 -> err, commit=0.
REQ-040 Word 0x80000000 mid-datagram, then PIXEL words -> err once, no writes until s_last; next datagram decodes normally.
REQ-041 s_length=8 with 10 bytes delivered; s_last on byte 10 -> exactly 2 words decoded, trailing bytes ignored.
REQ-042 SET_ADDR 0x00001FFF, then 2 PIXEL words -> one write at 0x1FFF, second dropped, no err.

Source files
------------

// File: rtl/pixel_proto_pkg.sv
// Shared pixel-stream protocol definitions: opcodes, decoder states,
// word field positions and pixel payload width.
package pixel_proto_pkg;

    typedef enum logic [1:0] {
        OP_SET_ADDR = 2'b00,
        OP_COMMIT   = 2'b01,
        OP_ILLEGAL  = 2'b10,
        OP_PIXEL    = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP
    } state_t;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 30;
    localparam int CH_MSB    = 29;
    localparam int CH_LSB    = 24;
    localparam int ADDR_MSB  = 23;
    localparam int ADDR_LSB  = 0;
    localparam int PAYLOAD_W = 30;

endpackage

// File: rtl/byte_word_packer.sv
// Packs payload bytes MSB-first into 32-bit words. Bytes at or beyond
// s_length are padding and are skipped; the byte index and any partial
// word are discarded at s_last. word_valid is combinational with the
// completing byte.
module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic [7:0]  s_data,
    input  logic [15:0] s_length,
    input  logic        drop,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [15:0] idx;
    logic [23:0] shift;
    logic        accept;

    // A byte is taken only inside the declared payload length and outside DROP
    always_comb begin
        accept     = s_valid && !drop && (idx < s_length);
        word_valid = accept && (idx[1:0] == 2'b11);
        word       = {shift, s_data};
    end

    // Byte index and partial-word shift register, both restarted at s_last
    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            shift <= '0;
        end else if (s_valid) begin
            if (s_last) begin
                idx   <= '0;
                shift <= '0;
            end else begin
                if (idx != '1) idx <= idx + 1'b1;
                if (accept) shift <= {shift[15:0], s_data};
            end
        end
    end

endmodule

// File: rtl/udp_pixel_decoder.sv
// UDP pixel-stream decoder: turns SET_ADDR / PIXEL / COMMIT words into
// per-channel pixel write strobes and frame-commit pulses.
// Optional statistics counters: define UDP_PIXEL_DECODER_STATS_EN.
module udp_pixel_decoder
    import pixel_proto_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int CH_NUM = 1
) (
    input  logic                 clk_125,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic                 s_last,
    input  logic [7:0]           s_data,
    input  logic [15:0]          s_length,
    output logic                 s_ready,
    output logic [CH_NUM-1:0]    wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [PAYLOAD_W-1:0] wr_data,
    output logic [CH_NUM-1:0]    commit,
    output logic                 err
`ifdef UDP_PIXEL_DECODER_STATS_EN
    ,
    output logic [31:0]          stat_pkts,
    output logic [31:0]          stat_pix,
    output logic [15:0]          stat_err
`endif
);

    state_t      state, state_next;
    logic        drop;
    logic        word_valid;
    logic [31:0] word;
    opcode_t     op;
    logic [5:0]  word_ch;
    logic        ch_ok;
    logic        addr_fits;

    logic [5:0]        chan;
    logic [ADDR_W-1:0] addr;
    logic              target_valid;

    assign s_ready = 1'b1;

    byte_word_packer u_packer (
        .clk        (clk_125),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_data     (s_data),
        .s_length   (s_length),
        .drop       (drop),
        .word_valid (word_valid),
        .word       (word)
    );

    // Field extraction and range checks on the word being completed
    always_comb begin
        op        = opcode_t'(word[OP_MSB:OP_LSB]);
        word_ch   = word[CH_MSB:CH_LSB];
        ch_ok     = int'(word_ch) < CH_NUM;
        addr_fits = (word[ADDR_MSB:ADDR_LSB] >> ADDR_W) == 24'd0;
    end

    // State register
    always_ff @(posedge clk_125) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state: s_last always returns to IDLE, even on an illegal word
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (s_valid && !s_last) state_next = ST_RECV;
            ST_RECV: begin
                if (s_valid && s_last)
                    state_next = ST_IDLE;
                else if (word_valid && op == OP_ILLEGAL)
                    state_next = ST_DROP;
            end
            ST_DROP: if (s_valid && s_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State outputs
    always_comb begin
        drop = (state == ST_DROP);
    end

    // Word decode; strobes are registered one cycle after the completing byte
    always_ff @(posedge clk_125) begin
        if (reset) begin
            wr_en        <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            commit       <= '0;
            err          <= 1'b0;
            chan         <= '0;
            addr         <= '0;
            target_valid <= 1'b0;
        end else begin
            wr_en  <= '0;
            commit <= '0;
            err    <= 1'b0;
            if (word_valid) begin
                unique case (op)
                    OP_SET_ADDR: begin
                        chan <= word_ch;
                        addr <= word[ADDR_W-1:0];
                        if (ch_ok && addr_fits) begin
                            target_valid <= 1'b1;
                        end else begin
                            target_valid <= 1'b0;
                            err          <= 1'b1;
                        end
                    end
                    OP_PIXEL: begin
                        if (target_valid) begin
                            wr_en   <= CH_NUM'(1) << chan;
                            wr_addr <= addr;
                            wr_data <= word[PAYLOAD_W-1:0];
                            addr    <= addr + 1'b1;
                            if (addr == '1) target_valid <= 1'b0;
                        end
                    end
                    OP_COMMIT: begin
                        if (ch_ok) commit <= CH_NUM'(1) << word_ch;
                        else       err    <= 1'b1;
                    end
                    default: err <= 1'b1;
                endcase
            end
        end
    end

`ifdef UDP_PIXEL_DECODER_STATS_EN
    // Saturating statistics counters
    always_ff @(posedge clk_125) begin
        if (reset) begin
            stat_pkts <= '0;
            stat_pix  <= '0;
            stat_err  <= '0;
        end else begin
            if (s_valid && s_last && stat_pkts != '1) stat_pkts <= stat_pkts + 1'b1;
            if (|wr_en && stat_pix != '1)             stat_pix  <= stat_pix + 1'b1;
            if (err && stat_err != '1)                stat_err  <= stat_err + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_pixel_decoder.sv
// Self-checking bench for udp_pixel_decoder (ADDR_W=13, CH_NUM=4).
module tb_udp_pixel_decoder;

    logic        clk_125 = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_last;
    logic [7:0]  s_data;
    logic [15:0] s_length;
    logic        s_ready;
    logic [3:0]  wr_en;
    logic [12:0] wr_addr;
    logic [29:0] wr_data;
    logic [3:0]  commit;
    logic        err;

    udp_pixel_decoder #(.ADDR_W(13), .CH_NUM(4)) dut (
        .clk_125  (clk_125),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_data   (s_data),
        .s_length (s_length),
        .s_ready  (s_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit   (commit),
        .err      (err)
    );

    always #4 clk_125 = ~clk_125;

    typedef struct packed {
        logic [3:0]  en;
        logic [12:0] addr;
        logic [29:0] data;
        logic [3:0]  cm;
        logic        er;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] tx[$];
    int         checks = 0;
    int         fails  = 0;

    // Scoreboard pop and compare for any cycle with a decoded output
    task automatic monitor_check();
        ev_t obs;
        ev_t e;
        if (|wr_en || |commit || err) begin
            obs      = '0;
            obs.en   = wr_en;
            obs.addr = (|wr_en) ? wr_addr : '0;
            obs.data = (|wr_en) ? wr_data : '0;
            obs.cm   = commit;
            obs.er   = err;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got en=%b addr=%h data=%h commit=%b err=%b, required no output",
                         obs.en, obs.addr, obs.data, obs.cm, obs.er);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    fails++;
                    $display("FAIL output_event: got en=%b addr=%h data=%h commit=%b err=%b, required en=%b addr=%h data=%h commit=%b err=%b",
                             obs.en, obs.addr, obs.data, obs.cm, obs.er, e.en, e.addr, e.data, e.cm, e.er);
                end
            end
        end
    endtask

    // One clock: outputs are sampled at the falling edge, inputs change after it
    task automatic cycle();
        @(posedge clk_125);
        @(negedge clk_125);
        monitor_check();
    endtask

    task automatic add_word(input logic [31:0] w);
        tx.push_back(w[31:24]);
        tx.push_back(w[23:16]);
        tx.push_back(w[15:8]);
        tx.push_back(w[7:0]);
    endtask

    task automatic send(input int len, input bit with_last);
        int n;
        n = tx.size();
        for (int i = 0; i < n; i++) begin
            s_valid  = 1'b1;
            s_data   = tx[i];
            s_last   = with_last && (i == n - 1);
            s_length = 16'(len);
            cycle();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tx.delete();
    endtask

    task automatic exp_wr(input logic [3:0] en, input logic [12:0] a, input logic [29:0] d);
        ev_t e;
        e = '0; e.en = en; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_cm(input logic [3:0] m);
        ev_t e;
        e = '0; e.cm = m;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        ev_t e;
        e = '0; e.er = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
        repeat (3) cycle();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_missing: got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_length = '0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        checks++;
        if (wr_en !== 4'b0 || commit !== 4'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: got en=%b commit=%b err=%b, required 0 0 0", wr_en, commit, err);
        end
        checks++;
        if (wr_addr !== 13'h0 || wr_data !== 30'h0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h data=%h, required 0 0", wr_addr, wr_data);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL s_ready: got %b, required 1", s_ready);
        end
    endtask

    task automatic test_pixel_write();
        add_word(32'h0000_0010); add_word(32'hC000_0001); add_word(32'hC000_0002);
        exp_wr(4'b0001, 13'h010, 30'h1);
        exp_wr(4'b0001, 13'h011, 30'h2);
        send(12, 1);
        drain("pixel_write");
    endtask

    task automatic test_bad_set_addr();
        add_word(32'h0000_2000); add_word(32'hC000_0005);
        add_word(32'h0500_0000); add_word(32'hC000_0006);
        exp_err();
        exp_err();
        send(16, 1);
        drain("bad_set_addr");
    endtask

    task automatic test_commit();
        add_word(32'h4300_0000); add_word(32'h4400_0000);
        exp_cm(4'b1000);
        exp_err();
        send(8, 1);
        drain("commit");
    endtask

    task automatic test_illegal_drop();
        add_word(32'h0100_0005); add_word(32'h8000_0000);
        add_word(32'hC000_0007); add_word(32'hC000_0008);
        exp_err();
        send(16, 1);
        drain("illegal_drop");
        add_word(32'hC000_0009);
        exp_wr(4'b0010, 13'h005, 30'h9);
        send(4, 1);
        drain("after_drop");
    endtask

    task automatic test_length_padding();
        add_word(32'h0000_0020); add_word(32'hC000_000A);
        tx.push_back(8'hC0); tx.push_back(8'h00);
        exp_wr(4'b0001, 13'h020, 30'hA);
        send(8, 1);
        drain("length_padding");
        add_word(32'hC000_000C);
        exp_wr(4'b0001, 13'h021, 30'hC);
        send(4, 1);
        drain("after_padding");
    endtask

    task automatic test_partial_word();
        add_word(32'h0000_0030);
        tx.push_back(8'hC0); tx.push_back(8'h00);
        send(6, 1);
        add_word(32'hC000_0003);
        exp_wr(4'b0001, 13'h030, 30'h3);
        send(4, 1);
        drain("partial_word");
    endtask

    task automatic test_addr_end();
        add_word(32'h0000_1FFF); add_word(32'hC000_0001); add_word(32'hC000_0002);
        exp_wr(4'b0001, 13'h1FFF, 30'h1);
        send(12, 1);
        add_word(32'hC000_0003);
        send(4, 1);
        drain("addr_end");
    endtask

    task automatic test_reset_mid_datagram();
        add_word(32'h0000_0040);
        tx.push_back(8'hC0); tx.push_back(8'h00);
        send(12, 0);
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        add_word(32'hC000_0004);
        send(4, 1);
        add_word(32'h0000_0050); add_word(32'hC000_0006);
        exp_wr(4'b0001, 13'h050, 30'h6);
        send(8, 1);
        drain("reset_mid_datagram");
    endtask

    task automatic test_back_to_back();
        add_word(32'h0000_0060); add_word(32'hC000_000D);
        exp_wr(4'b0001, 13'h060, 30'hD);
        exp_cm(4'b0100);
        exp_wr(4'b0001, 13'h061, 30'hE);
        // second datagram follows with no idle cycle
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = tx[i]; s_last = (i == 7); s_length = 16'd8;
            cycle();
        end
        tx.delete();
        add_word(32'h4200_0000); add_word(32'hC000_000E);
        send(8, 1);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_pixel_write();
        test_bad_set_addr();
        test_commit();
        test_illegal_drop();
        test_length_padding();
        test_partial_word();
        test_addr_end();
        test_reset_mid_datagram();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
